// File: rtl/prefix_add_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NREQ requesters,
// with a 2-entry tagged response queue. Optional self-check: PREFIX_ADD_ARB_CHECK_EN.
module prefix_add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout
`ifdef PREFIX_ADD_ARB_CHECK_EN
    ,
    output logic                    chk_err
`endif
);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             grant;
    logic             space;
    logic             pop;

    logic [IDW-1:0]   q_id   [2];
    logic [WIDTH-1:0] q_sum  [2];
    logic             q_cout [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;

    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign space     = (count < 2'd2) || (count == 2'd2 && pop);
    // Grants are suppressed while reset is asserted so nothing is handshaken that cycle.
    assign grant     = space && rst_n && gnt_found;

    always_comb begin
        logic [IDW:0] idx_wide;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_wide  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_wide = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx_wide >= (IDW+1)'(NREQ)) begin
                idx_wide = idx_wide - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[idx_wide[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_wide[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
            add_a              = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            add_b              = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        end
    end

    assign rsp_id   = rsp_valid ? q_id[head]   : '0;
    assign rsp_sum  = rsp_valid ? q_sum[head]  : '0;
    assign rsp_cout = rsp_valid ? q_cout[head] : 1'b0;

    // When full with a simultaneous pop, head==tail and the push overwrites the departing entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (grant) begin
                q_id[tail]   <= gnt_idx;
                q_sum[tail]  <= add_sum;
                q_cout[tail] <= add_cout;
                tail         <= ~tail;
                rr_ptr       <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
            end
            if (pop) begin
                head <= ~head;
            end
            case ({grant, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef PREFIX_ADD_ARB_CHECK_EN
    logic [WIDTH:0] ref_sum;
    assign ref_sum = {1'b0, add_a} + {1'b0, add_b};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (grant && ({add_cout, add_sum} != ref_sum)) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_prefix_add_arbiter.sv
// Directed bench for prefix_add_arbiter: stimulus pushes hand-computed responses into a
// scoreboard queue, an independent monitor compares them against rsp_* as they appear.
module tb_prefix_add_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic [7:0]        add_a;
    logic [7:0]        add_b;
    logic [7:0]        add_sum;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [7:0]        rsp_sum;
    logic              rsp_cout;
    logic              fault = 1'b0;
`ifdef PREFIX_ADD_ARB_CHECK_EN
    logic              chk_err;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Shared adder model; the fault flag flips the sum LSB to exercise the self-check.
    logic [8:0] full_sum;
    assign full_sum = {1'b0, add_a} + {1'b0, add_b};
    assign add_sum  = full_sum[7:0] ^ {7'b0, fault};
    assign add_cout = full_sum[8];

    prefix_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef PREFIX_ADD_ARB_CHECK_EN
        , .chk_err(chk_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic expect_grant(input string name, input logic [3:0] rdy,
                                input logic [1:0] id, input logic [7:0] sum, input logic cout);
        @(negedge clk);
        chk(name, {28'b0, req_ready}, {28'b0, rdy});
        if (rdy != 4'b0) sb.push_back('{id: id, sum: sum, cout: cout});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        sb.delete();
    endtask

    // Monitor: compares the head whenever valid (this also checks stability under stall),
    // pops on handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rsp_id",   {30'b0, rsp_id},   {30'b0, sb[0].id});
                chk("rsp_sum",  {24'b0, rsp_sum},  {24'b0, sb[0].sum});
                chk("rsp_cout", {31'b0, rsp_cout}, {31'b0, sb[0].cout});
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_id",    {30'b0, rsp_id},    32'd0);
        chk("reset_rsp_sum",   {24'b0, rsp_sum},   32'd0);
        chk("reset_rsp_cout",  {31'b0, rsp_cout},  32'd0);
        chk("reset_ready",     {28'b0, req_ready}, 32'd0);
`ifdef PREFIX_ADD_ARB_CHECK_EN
        chk("reset_chk_err",   {31'b0, chk_err},   32'd0);
`endif
        step();

        // Single request, carry out
        req_valid = 4'b0001;
        set_req(0, 8'hFF, 8'h01);
        expect_grant("single_grant", 4'b0001, 2'd0, 8'h00, 1'b1);
        chk("single_add_a", {24'b0, add_a}, 32'hFF);
        chk("single_add_b", {24'b0, add_b}, 32'h01);
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_latency", {31'b0, rsp_valid}, 32'd1);
        chk("idle_add_a", {24'b0, add_a}, 32'd0);
        chk("idle_add_b", {24'b0, add_b}, 32'd0);
        step();
        step();

        // Round-robin fairness from pointer 0
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 8'(i), 8'h10);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            expect_grant("rr_grant", 4'(1 << (k % 4)), 2'(k % 4), 8'(8'h10 + k % 4), 1'b0);
            step();
        end
        req_valid = 4'b0000;
        step();
        step();

        // Backpressure: two grants fill the queue, third grant coincides with first pop
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 8'h10, 8'h20);
        expect_grant("bp_grant0", 4'b0001, 2'd0, 8'h30, 1'b0);
        step();
        set_req(0, 8'h80, 8'h80);
        expect_grant("bp_grant1", 4'b0001, 2'd0, 8'h00, 1'b1);
        step();
        set_req(0, 8'h7F, 8'h01);
        expect_grant("bp_full0", 4'b0000, 2'd0, 8'h00, 1'b0);
        step();
        expect_grant("bp_full1", 4'b0000, 2'd0, 8'h00, 1'b0);
        step();
        rsp_ready = 1'b1;
        expect_grant("bp_grant2", 4'b0001, 2'd0, 8'h80, 1'b0);
        step();
        req_valid = 4'b0000;
        step();
        step();
        step();

        // Pointer hold: req2 alone, then req1 and req3 together
        req_valid = 4'b0100;
        set_req(2, 8'h05, 8'h06);
        for (int k = 0; k < 3; k++) begin
            expect_grant("hold_req2", 4'b0100, 2'd2, 8'h0B, 1'b0);
            step();
        end
        req_valid = 4'b1010;
        set_req(1, 8'h11, 8'h22);
        set_req(3, 8'hF0, 8'h20);
        expect_grant("hold_req3_first", 4'b1000, 2'd3, 8'h10, 1'b1);
        step();
        req_valid = 4'b0010;
        expect_grant("hold_req1_next", 4'b0010, 2'd1, 8'h33, 1'b0);
        step();
        req_valid = 4'b0000;
        step();
        step();

        // Reset mid-stream with a full queue and a pending request
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 8'h01, 8'h01);
        expect_grant("mid_fill0", 4'b0001, 2'd0, 8'h02, 1'b0);
        step();
        set_req(0, 8'h02, 8'h02);
        expect_grant("mid_fill1", 4'b0001, 2'd0, 8'h04, 1'b0);
        step();
        req_valid = 4'b1000;
        set_req(3, 8'h03, 8'h04);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_no_grant", {28'b0, req_ready}, 32'd0);
        step();
        sb.delete();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1001;
        set_req(0, 8'h09, 8'h09);
        @(negedge clk);
        chk("mid_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_reset_ptr0", {28'b0, req_ready}, 32'h1);
        if (req_ready == 4'b0001) sb.push_back('{id: 2'd0, sum: 8'h12, cout: 1'b0});
        step();
        req_valid = 4'b1000;
        expect_grant("mid_reset_req3", 4'b1000, 2'd3, 8'h07, 1'b0);
        step();
        req_valid = 4'b0000;
        step();
        step();

`ifdef PREFIX_ADD_ARB_CHECK_EN
        // Faulty adder sets the sticky error flag
        fault     = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 8'h03, 8'h04);
        expect_grant("chk_fault_grant", 4'b0001, 2'd0, 8'h06, 1'b0);
        step();
        fault = 1'b0;
        set_req(0, 8'h01, 8'h02);
        expect_grant("chk_good_grant", 4'b0001, 2'd0, 8'h03, 1'b0);
        chk("chk_err_set", {31'b0, chk_err}, 32'd1);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("chk_err_sticky", {31'b0, chk_err}, 32'd1);
        step();
        step();
`endif

        step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
